// File: rtl/mul_share_ctrl_pkg.sv
// rtl/mul_share_ctrl_pkg.sv - shared types and constants for the multiplier share controller
package mul_share_ctrl_pkg;

   // Controller phases; GUARD is the post-reset drain of a multiplier that has no reset
   typedef enum logic [2:0] {
      ST_GUARD  = 3'd0,
      ST_IDLE   = 3'd1,
      ST_LAUNCH = 3'd2,
      ST_WAIT   = 3'd3,
      ST_RESP   = 3'd4
   } state_t;

   localparam int DEF_N_REQ     = 4;
   localparam int DEF_W         = 3;
   localparam int DEF_TIMEOUT   = 32;
   localparam int DEF_GUARD     = 16;
   // Worst-case shift-add multiplier latency for W=3; GUARD must not be shorter
   localparam int MUL_MAX_LAT   = 12;
   // init is held two cycles so a multiplier still in its final state sees it too
   localparam int LAUNCH_CYCLES = 2;

   // Width of a requester index, never less than one bit
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mul_share_ctrl_rr_pick.sv
// rtl/mul_share_ctrl_rr_pick.sv - combinational round-robin select of a request vector
module mul_share_ctrl_rr_pick #(
   parameter int N_REQ = 4,
   parameter int IW    = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [IW-1:0]    winner,
   output logic             any_req
);

   // Lowest set bit at or after ptr; if none, wrap to the lowest set bit overall
   always_comb begin
      winner  = '0;
      any_req = |req;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[i]) winner = IW'(i);
      end
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[i] && (IW'(i) >= ptr)) winner = IW'(i);
      end
   end

endmodule

// File: rtl/mul_share_ctrl.sv
// rtl/mul_share_ctrl.sv - round-robin sharing of one shift-add multiplier between requesters
module mul_share_ctrl
   import mul_share_ctrl_pkg::*;
#(
   parameter int N_REQ   = DEF_N_REQ,
   parameter int W       = DEF_W,
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int GUARD   = DEF_GUARD
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ*W-1:0] mr_in,
   input  logic [N_REQ*W-1:0] md_in,
   output logic [N_REQ-1:0]   ack,
   output logic [N_REQ-1:0]   rsp_valid,
   output logic [2*W-1:0]     rsp_pp,
   output logic               rsp_err,
   output logic               busy,
   output logic [W-1:0]       mul_mr,
   output logic [W-1:0]       mul_md,
   output logic               mul_init,
   input  logic               mul_done,
   input  logic [2*W-1:0]     mul_pp
);

   localparam int IW   = idx_w(N_REQ);
   localparam int CMAX = (GUARD > TIMEOUT) ? GUARD : TIMEOUT;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [CW-1:0] GUARD_LAST  = CW'(GUARD - 1);
   localparam logic [CW-1:0] TO_LAST     = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] LAUNCH_LAST = CW'(LAUNCH_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST    = IW'(N_REQ - 1);

   state_t             state, state_n;
   logic [CW-1:0]      cnt, cnt_n;
   logic [IW-1:0]      ptr, ptr_n;
   logic [IW-1:0]      win, win_n;
   logic [IW-1:0]      pick;
   logic               any_req;

   logic [N_REQ-1:0]   ack_n, rsp_valid_n;
   logic [2*W-1:0]     rsp_pp_n;
   logic               rsp_err_n, busy_n, mul_init_n;
   logic [W-1:0]       mul_mr_n, mul_md_n;

   mul_share_ctrl_rr_pick #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_rr_pick (
      .req     (req),
      .ptr     (ptr),
      .winner  (pick),
      .any_req (any_req)
   );

   // One counter serves the guard drain, the two init cycles and the wait timeout
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      ptr_n       = ptr;
      win_n       = win;
      ack_n       = '0;
      rsp_valid_n = '0;
      rsp_pp_n    = '0;
      rsp_err_n   = 1'b0;
      mul_init_n  = 1'b0;
      mul_mr_n    = mul_mr;
      mul_md_n    = mul_md;
      case (state)
         ST_GUARD: begin
            if (cnt == GUARD_LAST) begin
               state_n = ST_IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         ST_IDLE: begin
            if (any_req) begin
               win_n       = pick;
               mul_mr_n    = mr_in[int'(pick)*W +: W];
               mul_md_n    = md_in[int'(pick)*W +: W];
               ack_n[pick] = 1'b1;
               mul_init_n  = 1'b1;
               cnt_n       = '0;
               state_n     = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            if (cnt == LAUNCH_LAST) begin
               cnt_n   = '0;
               state_n = ST_WAIT;
            end else begin
               cnt_n      = cnt + 1'b1;
               mul_init_n = 1'b1;
            end
         end
         ST_WAIT: begin
            // A done in the last allowed cycle still wins over the timeout
            if (mul_done) begin
               rsp_valid_n[win] = 1'b1;
               rsp_pp_n         = mul_pp;
               state_n          = ST_RESP;
            end else if (cnt == TO_LAST) begin
               rsp_valid_n[win] = 1'b1;
               rsp_err_n        = 1'b1;
               state_n          = ST_RESP;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         ST_RESP: begin
            ptr_n   = (win == IDX_LAST) ? '0 : win + 1'b1;
            state_n = ST_IDLE;
         end
         default: begin
            cnt_n   = '0;
            state_n = ST_GUARD;
         end
      endcase
      busy_n = (state_n != ST_IDLE);
   end

   // State and every output registered; reset aborts any operation in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_GUARD;
         cnt       <= '0;
         ptr       <= '0;
         win       <= '0;
         ack       <= '0;
         rsp_valid <= '0;
         rsp_pp    <= '0;
         rsp_err   <= 1'b0;
         busy      <= 1'b1;
         mul_init  <= 1'b0;
         mul_mr    <= '0;
         mul_md    <= '0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         ptr       <= ptr_n;
         win       <= win_n;
         ack       <= ack_n;
         rsp_valid <= rsp_valid_n;
         rsp_pp    <= rsp_pp_n;
         rsp_err   <= rsp_err_n;
         busy      <= busy_n;
         mul_init  <= mul_init_n;
         mul_mr    <= mul_mr_n;
         mul_md    <= mul_md_n;
      end
   end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb/tb_mul_share_ctrl.sv - self-checking bench for mul_share_ctrl
module tb_mul_share_ctrl;

   localparam int N  = 4;
   localparam int W  = 3;
   localparam int TO = 32;
   localparam int GD = 16;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] mr_in = '0;
   logic [N*W-1:0] md_in = '0;
   logic [N-1:0]   ack, rsp_valid;
   logic [2*W-1:0] rsp_pp;
   logic           rsp_err, busy, mul_init;
   logic [W-1:0]   mul_mr, mul_md;

   // behavioural multiplier: no reset, init accepted only when idle, done is a level
   logic           m_run = 1'b0;
   logic           m_done = 1'b0;
   logic [2*W-1:0] m_pp = 6'h15;
   int             m_cnt = 0;
   int             m_lat = 4;
   bit             m_nodone = 1'b0;

   int             errors = 0;
   int             checks = 0;
   int             ptr = 0;
   logic [N-1:0]   pend = '0;
   logic [W-1:0]   mra [N];
   logic [W-1:0]   mda [N];
   int             wc;

   always #5 clk = ~clk;

   mul_share_ctrl #(
      .N_REQ   (N),
      .W       (W),
      .TIMEOUT (TO),
      .GUARD   (GD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .mr_in     (mr_in),
      .md_in     (md_in),
      .ack       (ack),
      .rsp_valid (rsp_valid),
      .rsp_pp    (rsp_pp),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .mul_mr    (mul_mr),
      .mul_md    (mul_md),
      .mul_init  (mul_init),
      .mul_done  (m_done),
      .mul_pp    (m_pp)
   );

   // product is formed from the operand pins at completion, so unstable operands show up
   always @(posedge clk) begin
      if (!m_run) begin
         if (mul_init === 1'b1) begin
            m_run  <= 1'b1;
            m_done <= 1'b0;
            m_cnt  <= m_lat;
         end
      end else if (m_cnt <= 1) begin
         m_run <= 1'b0;
         if (m_nodone) m_pp <= 6'h2A;
         else begin
            m_done <= 1'b1;
            m_pp   <= {3'b000, mul_mr} * {3'b000, mul_md};
         end
      end else begin
         m_cnt <= m_cnt - 1;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic raise(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      mra[i] = a;
      mda[i] = b;
      mr_in[i*W +: W] = a;
      md_in[i*W +: W] = b;
      req[i]  = 1'b1;
      pend[i] = 1'b1;
   endtask

   // reference arbitration: first pending requester at or after the pointer, wrapping
   function automatic int rr_expect();
      for (int k = 0; k < N; k++) begin
         if (pend[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic chk_reset();
      chk("rst_ack", 32'(ack), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_pp", 32'(rsp_pp), 0);
      chk("rst_rsp_err", 32'(rsp_err), 0);
      chk("rst_mul_init", 32'(mul_init), 0);
      chk("rst_mul_mr", 32'(mul_mr), 0);
      chk("rst_mul_md", 32'(mul_md), 0);
      chk("rst_busy", 32'(busy), 1);
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      req  = '0;
      pend = '0;
      step();
      chk_reset();
      step();
      rst = 1'b0;
      ptr = 0;
   endtask

   // no grant and no response may appear while the guard drains
   task automatic guard_quiet();
      int bad = 0;
      for (int i = 0; i < GD; i++) begin
         step();
         if (ack !== '0 || rsp_valid !== '0) bad++;
         if (i == 0 && busy !== 1'b1) bad++;
      end
      chk("guard_quiet", bad, 0);
   endtask

   task automatic add_random(input int excl);
      for (int i = 0; i < N; i++) begin
         if (i != excl && !pend[i] && $urandom_range(0, 1) == 1)
            raise(i, W'($urandom_range(0, 7)), W'($urandom_range(0, 7)));
      end
   endtask

   task automatic serve(input int lat, input bit rearm, input bit add_more, output int wait_cyc);
      int w;
      int cyc;
      logic [2*W-1:0] epp;
      logic eerr;
      w = rr_expect();
      if (w < 0) w = 0;
      m_lat = lat;
      cyc = 0;
      while (ack === '0 && cyc < 200) begin
         step();
         cyc++;
      end
      wait_cyc = cyc;
      chk("ack_grant", 32'(ack), 32'(1) << w);
      chk("init_first", 32'(mul_init), 1);
      chk("mul_mr_latch", 32'(mul_mr), 32'(mra[w]));
      chk("mul_md_latch", 32'(mul_md), 32'(mda[w]));
      eerr = m_nodone;
      epp  = m_nodone ? '0 : {3'b000, mra[w]} * {3'b000, mda[w]};
      req[w]  = 1'b0;
      pend[w] = 1'b0;
      step();
      chk("ack_pulse", 32'(ack), 0);
      chk("init_second", 32'(mul_init), 1);
      if (rearm) raise(w, mra[w], mda[w]);
      if (add_more) add_random(w);
      step();
      chk("init_low", 32'(mul_init), 0);
      cyc = 2;
      while (rsp_valid === '0 && cyc < 100) begin
         step();
         cyc++;
      end
      chk("rsp_valid", 32'(rsp_valid), 32'(1) << w);
      chk("rsp_pp", 32'(rsp_pp), 32'(epp));
      chk("rsp_err", 32'(rsp_err), 32'(eerr));
      chk("rsp_latency", cyc, eerr ? TO + 2 : lat + 2);
      ptr = (w + 1) % N;
      step();
      chk("rsp_pulse", 32'(rsp_valid), 0);
   endtask

   initial begin
      int cyc;

      // reset values, guard hold-off, first product 5*6
      rst = 1'b1;
      repeat (3) step();
      chk_reset();
      rst = 1'b0;
      raise(0, 3'd5, 3'd6);
      guard_quiet();
      serve(5, 1'b0, 1'b0, wc);
      chk("guard_len", wc, 1);

      // all four requesting from pointer 0: order 0,1,2,3,0
      do_reset();
      for (int i = 0; i < N; i++) raise(i, W'(i * 2 + 1), 3'd7);
      guard_quiet();
      for (int s = 0; s < 5; s++) begin
         chk("rr_order", rr_expect(), s % N);
         serve($urandom_range(2, 12), (s < 4) ? 1'b1 : 1'b0, 1'b0, wc);
      end
      req  = '0;
      pend = '0;

      // zero operands, then 7*7 back-to-back with a single idle cycle between
      raise(0, 3'd0, 3'd7);
      raise(1, 3'd7, 3'd0);
      serve(3, 1'b0, 1'b0, wc);
      serve(4, 1'b0, 1'b0, wc);
      raise(2, 3'd7, 3'd7);
      raise(3, 3'd7, 3'd7);
      serve(6, 1'b0, 1'b0, wc);
      serve(2, 1'b0, 1'b0, wc);
      chk("b2b_gap", wc, 1);

      // stale done=1 with 49 still on pp: new result must be 2*3
      raise(1, 3'd2, 3'd3);
      serve(5, 1'b0, 1'b0, wc);

      // multiplier that never finishes: timeout error, then normal service
      m_nodone = 1'b1;
      raise(2, 3'd3, 3'd3);
      serve(4, 1'b0, 1'b0, wc);
      m_nodone = 1'b0;
      raise(2, 3'd3, 3'd3);
      serve(7, 1'b0, 1'b0, wc);

      // reset while waiting on the multiplier: abort without a response
      raise(3, 3'd6, 3'd5);
      m_lat = 12;
      cyc = 0;
      while (ack === '0 && cyc < 200) begin
         step();
         cyc++;
      end
      chk("abort_ack", 32'(ack), 32'(1) << 3);
      req  = '0;
      pend = '0;
      cyc  = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (rsp_valid !== '0) cyc++;
      end
      chk("abort_no_rsp", cyc, 0);
      do_reset();
      raise(1, 3'd4, 3'd5);
      guard_quiet();
      serve(6, 1'b0, 1'b0, wc);
      chk("abort_guard_len", wc, 1);

      // randomized traffic with requests arriving while the controller is busy
      for (int n = 0; n < 30; n++) begin
         if (pend == '0) raise($urandom_range(0, N - 1), W'($urandom_range(0, 7)), W'($urandom_range(0, 7)));
         m_nodone = ($urandom_range(0, 7) == 0);
         serve($urandom_range(2, 12), 1'b0, 1'b1, wc);
      end
      m_nodone = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
